// File: rtl/status_flags.sv
// CPU status/condition register: masked ALU flag latch, direct SC ops, IRQ shadowing, branch conditions.
// Optional FLAG_BYPASS_EN: alu_c/cond_true forward the next-state SC instead of the registered one.
module status_flags #(
   parameter logic [7:0] SC_RESET = 8'hC0,
   parameter int         COND_W   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              alu_flag_we,
   input  logic [3:0]        alu_flags,
   input  logic [3:0]        alu_flag_mask,
   input  logic              sc_wr_en,
   input  logic [1:0]        sc_wr_op,
   input  logic [7:0]        sc_wr_data,
   input  logic              irq_enter,
   input  logic [1:0]        irq_level,
   input  logic              irq_return,
   input  logic [COND_W-1:0] cond,
   output logic [7:0]        sc,
   output logic              alu_c,
   output logic              cond_true,
   output logic              shadow_valid,
   output logic              nest_err
);

   localparam logic [1:0] OP_LD  = 2'd0;
   localparam logic [1:0] OP_AND = 2'd1;
   localparam logic [1:0] OP_OR  = 2'd2;
   localparam logic [1:0] OP_XOR = 2'd3;

   logic [7:0] sc_q, shadow_q, sc_nxt, shadow_nxt, flag_src;
   logic       shadow_valid_q, shadow_valid_nxt, nest_err_q, nest_err_nxt;

   // f = {S,V,C,Z}
   function automatic logic cond_eval(input logic [COND_W-1:0] c, input logic [3:0] f);
      logic s, v, cf, z, lt;
      {s, v, cf, z} = f;
      lt = s ^ v;
      case (c)
         4'd0:    cond_eval = cf;
         4'd1:    cond_eval = ~cf;
         4'd2:    cond_eval = z;
         4'd3:    cond_eval = ~z;
         4'd4:    cond_eval = lt;
         4'd5:    cond_eval = lt | z;
         4'd6:    cond_eval = ~(lt | z);
         4'd7:    cond_eval = ~lt;
         4'd8:    cond_eval = v;
         4'd9:    cond_eval = ~v;
         4'd10:   cond_eval = ~s;
         4'd11:   cond_eval = s;
         4'd12:   cond_eval = 1'b1;
         default: cond_eval = 1'b0;
      endcase
   endfunction

   always_comb begin
      sc_nxt           = sc_q;
      shadow_nxt       = shadow_q;
      shadow_valid_nxt = shadow_valid_q;
      nest_err_nxt     = nest_err_q;
      if (irq_return) begin
         // A return with nothing shadowed is silently ignored.
         if (shadow_valid_q) begin
            sc_nxt           = shadow_q;
            shadow_valid_nxt = 1'b0;
         end
      end else if (irq_enter) begin
         shadow_nxt       = sc_q;
         shadow_valid_nxt = 1'b1;
         nest_err_nxt     = nest_err_q | shadow_valid_q;
         sc_nxt           = {irq_level, sc_q[5:0]};
      end else if (sc_wr_en) begin
         case (sc_wr_op)
            OP_LD:   sc_nxt = sc_wr_data;
            OP_AND:  sc_nxt = sc_q & sc_wr_data;
            OP_OR:   sc_nxt = sc_q | sc_wr_data;
            OP_XOR:  sc_nxt = sc_q ^ sc_wr_data;
            default: sc_nxt = sc_q;
         endcase
      end else if (alu_flag_we) begin
         sc_nxt[3:0] = (sc_q[3:0] & ~alu_flag_mask) | (alu_flags & alu_flag_mask);
      end
      sc_nxt[5] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sc_q           <= SC_RESET;
         shadow_q       <= 8'h00;
         shadow_valid_q <= 1'b0;
         nest_err_q     <= 1'b0;
      end else begin
         sc_q           <= sc_nxt;
         shadow_q       <= shadow_nxt;
         shadow_valid_q <= shadow_valid_nxt;
         nest_err_q     <= nest_err_nxt;
      end
   end

`ifdef FLAG_BYPASS_EN
   assign flag_src = sc_nxt;
`else
   assign flag_src = sc_q;
`endif

   assign sc           = sc_q;
   assign shadow_valid = shadow_valid_q;
   assign nest_err     = nest_err_q;
   assign alu_c        = flag_src[1];
   assign cond_true    = cond_eval(cond, flag_src[3:0]);

endmodule
